// File: rtl/fpu_addsub_prenorm.sv
// Three-stage pre-normalisation for floating-point add/subtract: unpack, order by
// magnitude, then align the smaller fraction with guard/round/sticky and resolve the sign.
module fpu_addsub_prenorm #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    localparam int W     = 1 + EXP_W + FRAC_W,
    localparam int FW    = FRAC_W + 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     opa,
    input  logic [W-1:0]     opb,
    input  logic             fpu_op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] exp_out,
    output logic [FW-1:0]    fracta_out,
    output logic [FW-1:0]    fractb_out,
    output logic             sticky_out,
    output logic             eff_sub,
    output logic             sign_out,
    output logic             special_out
);

    localparam int SHW = $clog2(FW + 1);
    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};

    // Handshake: a beat moves on a clock edge where valid && ready. The whole pipe
    // advances together whenever the output register is empty or being drained.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ---------------- S1: capture and unpack ----------------
    logic [EXP_W-1:0]  raw_exp_a, raw_exp_b;
    logic [FRAC_W-1:0] raw_frac_a, raw_frac_b;

    assign raw_exp_a  = opa[W-2 -: EXP_W];
    assign raw_exp_b  = opb[W-2 -: EXP_W];
    assign raw_frac_a = opa[FRAC_W-1:0];
    assign raw_frac_b = opb[FRAC_W-1:0];

    logic              s1_valid;
    logic              s1_sign_a, s1_sign_b, s1_op;
    logic [EXP_W-1:0]  s1_exp_a, s1_exp_b;
    logic [FRAC_W-1:0] s1_mant_a, s1_mant_b;
    logic [FW-1:0]     s1_frac_a, s1_frac_b;
    logic              s1_special;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_sign_a  <= 1'b0;
            s1_sign_b  <= 1'b0;
            s1_op      <= 1'b0;
            s1_exp_a   <= '0;
            s1_exp_b   <= '0;
            s1_mant_a  <= '0;
            s1_mant_b  <= '0;
            s1_frac_a  <= '0;
            s1_frac_b  <= '0;
            s1_special <= 1'b0;
        end else if (adv) begin
            s1_valid   <= in_valid;
            s1_sign_a  <= opa[W-1];
            s1_sign_b  <= opb[W-1];
            s1_op      <= fpu_op;
            // Denormals share the exponent of the smallest normal and lose the hidden bit.
            s1_exp_a   <= (raw_exp_a == '0) ? EXP_W'(1) : raw_exp_a;
            s1_exp_b   <= (raw_exp_b == '0) ? EXP_W'(1) : raw_exp_b;
            s1_mant_a  <= raw_frac_a;
            s1_mant_b  <= raw_frac_b;
            s1_frac_a  <= {(raw_exp_a != '0), raw_frac_a, 3'b000};
            s1_frac_b  <= {(raw_exp_b != '0), raw_frac_b, 3'b000};
            s1_special <= (raw_exp_a == EXP_ONES) || (raw_exp_b == EXP_ONES);
        end
    end

    // ---------------- S2: order by magnitude ----------------
    logic [EXP_W+FRAC_W-1:0] mag_a, mag_b;
    logic                    b_gt_a;
    logic                    sign_b_eff;

    assign mag_a      = {s1_exp_a, s1_mant_a};
    assign mag_b      = {s1_exp_b, s1_mant_b};
    assign b_gt_a     = (mag_b > mag_a);
    assign sign_b_eff = s1_sign_b ^ s1_op;

    logic             s2_valid;
    logic             s2_sign_l, s2_sign_s;
    logic [EXP_W-1:0] s2_exp_l;
    logic [EXP_W-1:0] s2_diff;
    logic [FW-1:0]    s2_frac_l, s2_frac_s;
    logic             s2_eq;
    logic             s2_special;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            s2_sign_l  <= 1'b0;
            s2_sign_s  <= 1'b0;
            s2_exp_l   <= '0;
            s2_diff    <= '0;
            s2_frac_l  <= '0;
            s2_frac_s  <= '0;
            s2_eq      <= 1'b0;
            s2_special <= 1'b0;
        end else if (adv) begin
            s2_valid   <= s1_valid;
            s2_eq      <= (mag_a == mag_b);
            s2_special <= s1_special;
            if (b_gt_a) begin
                s2_sign_l <= sign_b_eff;
                s2_sign_s <= s1_sign_a;
                s2_exp_l  <= s1_exp_b;
                s2_diff   <= s1_exp_b - s1_exp_a;
                s2_frac_l <= s1_frac_b;
                s2_frac_s <= s1_frac_a;
            end else begin
                s2_sign_l <= s1_sign_a;
                s2_sign_s <= sign_b_eff;
                s2_exp_l  <= s1_exp_a;
                s2_diff   <= s1_exp_a - s1_exp_b;
                s2_frac_l <= s1_frac_a;
                s2_frac_s <= s1_frac_b;
            end
        end
    end

    // ---------------- S3: align and resolve sign ----------------
    logic [SHW-1:0] shamt;
    logic [FW-1:0]  shifted;
    logic [FW-1:0]  lost_mask;
    logic           sticky;
    logic           sub_now;
    logic           sign_now;

    always_comb begin
        shamt = SHW'(s2_diff);
        if (32'(s2_diff) >= 32'(FW)) begin
            shamt = SHW'(FW);
        end
    end

    // A full-width shift empties the fraction and makes the mask all ones.
    assign shifted   = s2_frac_s >> shamt;
    assign lost_mask = ~({FW{1'b1}} << shamt);
    assign sticky    = |(s2_frac_s & lost_mask);
    assign sub_now   = s2_sign_l ^ s2_sign_s;
    // Exact cancellation yields +0 under round-to-nearest.
    assign sign_now  = (sub_now && s2_eq) ? 1'b0 : s2_sign_l;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            exp_out     <= '0;
            fracta_out  <= '0;
            fractb_out  <= '0;
            sticky_out  <= 1'b0;
            eff_sub     <= 1'b0;
            sign_out    <= 1'b0;
            special_out <= 1'b0;
        end else if (adv) begin
            out_valid   <= s2_valid;
            exp_out     <= s2_exp_l;
            fracta_out  <= s2_frac_l;
            fractb_out  <= {shifted[FW-1:1], shifted[0] | sticky};
            sticky_out  <= sticky;
            eff_sub     <= sub_now;
            sign_out    <= sign_now;
            special_out <= s2_special;
        end
    end

endmodule

// File: tb/tb_fpu_addsub_prenorm.sv
// Bench for fpu_addsub_prenorm: directed vectors checked against an arithmetic model
// of the pre-normalisation rules, with literal expectations pinning that model.
module tb_fpu_addsub_prenorm;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int W      = 1 + EXP_W + FRAC_W;
    localparam int FW     = FRAC_W + 4;
    localparam int RW     = EXP_W + 2 * FW + 4;

    logic             clk;
    logic             rst;
    logic [W-1:0]     opa, opb;
    logic             fpu_op;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [EXP_W-1:0] exp_out;
    logic [FW-1:0]    fracta_out, fractb_out;
    logic             sticky_out, eff_sub, sign_out, special_out;

    fpu_addsub_prenorm #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
        .clk(clk), .rst(rst), .opa(opa), .opb(opb), .fpu_op(fpu_op),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .exp_out(exp_out), .fracta_out(fracta_out), .fractb_out(fractb_out),
        .sticky_out(sticky_out), .eff_sub(eff_sub), .sign_out(sign_out),
        .special_out(special_out)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [RW-1:0] exp_q[$];

    logic [RW-1:0] dut_vec;
    assign dut_vec = {exp_out, fracta_out, fractb_out, sticky_out, eff_sub, sign_out, special_out};

    // ---------------- model: plain arithmetic on the operand fields ----------------
    function automatic logic [RW-1:0] model(input logic [31:0] a, input logic [31:0] b, input logic op);
        int     exa, exb, ea, eb, el, es, diff;
        longint fra, frb, ka, kb, fl, fs, sh, fbo;
        bit     sa, sb, sl, ss, eq, eff, sgn, st, spec;
        exa = int'(a[30:23]);
        exb = int'(b[30:23]);
        fra = longint'(a[22:0]);
        frb = longint'(b[22:0]);
        sa  = a[31];
        sb  = b[31] ^ op;
        ea  = (exa == 0) ? 1 : exa;
        eb  = (exb == 0) ? 1 : exb;
        ka  = longint'(ea) * 8388608 + fra;
        kb  = longint'(eb) * 8388608 + frb;
        eq  = (ka == kb);
        if (kb > ka) begin
            el = eb; es = ea; sl = sb; ss = sa;
            fl = ((exb != 0) ? 67108864 : 0) + frb * 8;
            fs = ((exa != 0) ? 67108864 : 0) + fra * 8;
        end else begin
            el = ea; es = eb; sl = sa; ss = sb;
            fl = ((exa != 0) ? 67108864 : 0) + fra * 8;
            fs = ((exb != 0) ? 67108864 : 0) + frb * 8;
        end
        diff = el - es;
        if (diff >= 27) begin
            sh = 0;
            st = (fs != 0);
        end else begin
            sh = fs / (longint'(1) << diff);
            st = (fs % (longint'(1) << diff)) != 0;
        end
        fbo  = sh | longint'(st);
        eff  = sl ^ ss;
        sgn  = (eff && eq) ? 1'b0 : sl;
        spec = (exa == 255) || (exb == 255);
        return {8'(el), 27'(fl), 27'(fbo), st, eff, sgn, spec};
    endfunction

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ---------------- scoreboard / compare process ----------------
    logic          stall_prev = 1'b0;
    logic [RW-1:0] held_vec;
    logic [RW-1:0] expv;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            check("in_ready_rule", RW'(in_ready), RW'(!out_valid || out_ready));
            if (stall_prev) begin
                check("stall_valid_hold", RW'(out_valid), RW'(1));
                check("stall_data_hold", dut_vec, held_vec);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%h required=none", dut_vec);
                end else begin
                    expv = exp_q.pop_front();
                    check("result", dut_vec, expv);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(opa, opb, fpu_op));
            stall_prev = out_valid && !out_ready;
            held_vec   = dut_vec;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op);
        bit ok;
        ok       = 1'b0;
        opa      = a;
        opb      = b;
        fpu_op   = op;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_accept", RW'(0), RW'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        check("drain_empty", RW'(exp_q.size()), RW'(0));
    endtask

    // ---------------- directed vectors {opa, opb, op} ----------------
    logic [64:0] vecs[12];
    initial begin
        vecs = '{
            {32'h3F800000, 32'h3F800000, 1'b0},
            {32'h3F800000, 32'h3F800000, 1'b1},
            {32'h3F800000, 32'h40000000, 1'b1},
            {32'h3F800000, 32'h30800000, 1'b0},
            {32'hBFC00000, 32'h3F400000, 1'b0},
            {32'h3F800000, 32'h3C000001, 1'b0},
            {32'h00000003, 32'h00000001, 1'b1},
            {32'h00400000, 32'h00800000, 1'b0},
            {32'h80000000, 32'h80000000, 1'b1},
            {32'h7FC00000, 32'hFF800000, 1'b1},
            {32'h41200000, 32'hC1200001, 1'b1},
            {32'hC0A00000, 32'h3E000000, 1'b1}
        };
    end

    int  cnt;
    bit  seen;

    // ---------------- main sequence ----------------
    initial begin
        rst       = 1'b1;
        opa       = '0;
        opb       = '0;
        fpu_op    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", RW'(out_valid), RW'(0));
        check("reset_outputs", dut_vec, RW'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_in_ready", RW'(in_ready), RW'(1));

        // Literal expectations that pin the model.
        check("model_equal_add", model(32'h3F800000, 32'h3F800000, 1'b0),
              {8'h7F, 27'h4000000, 27'h4000000, 1'b0, 1'b0, 1'b0, 1'b0});
        check("model_equal_cancel", model(32'h3F800000, 32'h3F800000, 1'b1),
              {8'h7F, 27'h4000000, 27'h4000000, 1'b0, 1'b1, 1'b0, 1'b0});
        check("model_swap", model(32'h3F800000, 32'h40000000, 1'b1),
              {8'h80, 27'h4000000, 27'h2000000, 1'b0, 1'b1, 1'b1, 1'b0});
        check("model_full_shift", model(32'h3F800000, 32'h30800000, 1'b0),
              {8'h7F, 27'h4000000, 27'h0000001, 1'b1, 1'b0, 1'b0, 1'b0});
        check("model_special", model(32'h7F800000, 32'h3F800000, 1'b0),
              {8'hFF, 27'h4000000, 27'h0000001, 1'b1, 1'b0, 1'b0, 1'b1});

        // Latency: a single beat must appear after exactly three edges.
        send(32'h3F800000, 32'h3F800000, 1'b0);
        cnt = 1;
        while (!out_valid && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("latency", RW'(cnt), RW'(3));
        drain();

        // Throughput: all vectors back to back.
        foreach (vecs[i]) send(vecs[i][64:33], vecs[i][32:1], vecs[i][0]);
        drain();

        // Back-pressure: four beats, then a five-cycle stall with a beat offered.
        send(32'h3F800000, 32'h40000000, 1'b1);
        send(32'h3F800000, 32'h30800000, 1'b0);
        send(32'hBFC00000, 32'h3F400000, 1'b0);
        send(32'h41200000, 32'hC1200001, 1'b1);
        out_ready = 1'b0;
        opa       = 32'h12345678;
        opb       = 32'h3F800000;
        fpu_op    = 1'b0;
        in_valid  = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("stall_in_ready", RW'(in_ready), RW'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset with two beats in flight discards both.
        send(32'h3F800000, 32'h3F800000, 1'b0);
        send(32'h3F800000, 32'h40000000, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_flush_valid", RW'(out_valid), RW'(0));
        rst  = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("reset_no_late_beat", RW'(seen), RW'(0));

        // Infinity operand.
        send(32'h7F800000, 32'h3F800000, 1'b0);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("special_flag", RW'(special_out), RW'(1));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
